// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, constants and gray conversion for the capture path
package cam_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_VSYNC, CAPTURE, WRITE, DONE} state_t;

  localparam int NPIX   = 784;
  localparam int CROP   = 448;
  localparam int ADDR_W = $clog2(NPIX);

  // Bit replication widens each channel to 8 bits; green counts twice.
  function automatic logic [7:0] rgb565_to_gray(input logic [15:0] p);
    logic [7:0] r8, g8, b8;
    logic [9:0] sum;
    r8  = {p[15:11], p[15:13]};
    g8  = {p[10:5], p[10:9]};
    b8  = {p[4:0], p[4:2]};
    sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/block_row_accumulator.sv
// rtl/block_row_accumulator.sv - per-block running sums for one row of blocks
module block_row_accumulator #(
  parameter int NB    = 28,
  parameter int IW    = 5,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_all,
  input  logic             add_en,
  input  logic [IW-1:0]    add_idx,
  input  logic [7:0]       add_val,
  input  logic             rd_clr,
  input  logic [IW-1:0]    rd_idx,
  output logic [ACC_W-1:0] rd_data
);

  logic [ACC_W-1:0] acc [NB];

  always_ff @(posedge clk) begin
    if (!rst_n || clear_all) begin
      for (int i = 0; i < NB; i++) acc[i] <= '0;
    end else begin
      if (add_en && int'(add_idx) < NB) acc[add_idx] <= acc[add_idx] + ACC_W'(add_val);
      // A cleared slot starts the next block row from zero.
      if (rd_clr && int'(rd_idx) < NB) acc[rd_idx] <= '0;
    end
  end

  assign rd_data = (int'(rd_idx) < NB) ? acc[rd_idx] : '0;

endmodule

// File: rtl/frame_downsample_writer.sv
// rtl/frame_downsample_writer.sv - crop, box-average and write a gray thumbnail to BRAM
module frame_downsample_writer
  import cam_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int X0       = 96,
  parameter int Y0       = 16,
  parameter int BLK_LOG2 = 4,
  parameter int NB       = CROP >> BLK_LOG2,
  parameter int INVERT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              vsync,
  input  logic              pixel_valid,
  input  logic [15:0]       pixel_data,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_din,
  output logic              bram_we,
  output logic              bram_en,
  output logic              frame_done,
  output logic              busy
);

  localparam int BLK     = 1 << BLK_LOG2;
  localparam int CROP_PX = NB * BLK;
  localparam int IW      = (NB > 1) ? $clog2(NB) : 1;
  localparam int ACC_W   = 8 + 2 * BLK_LOG2;

  localparam logic [9:0] X_LAST    = 10'(IMG_W - 1);
  localparam logic [9:0] Y_END     = 10'(IMG_H);
  localparam logic [9:0] X_LO      = 10'(X0);
  localparam logic [9:0] X_HI      = 10'(X0 + CROP_PX);
  localparam logic [9:0] Y_LO      = 10'(Y0);
  localparam logic [9:0] Y_HI      = 10'(Y0 + CROP_PX);
  localparam logic [9:0] ROW0_LAST = 10'(Y0 + BLK - 1);
  localparam logic [9:0] BLK_V     = 10'(BLK);
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
  localparam logic [ADDR_W-1:0] NB_A = ADDR_W'(NB);

  state_t state, state_nx;
  logic [9:0] x, y, row_last, xo;
  logic [IW-1:0] bx, by;
  logic [ADDR_W-1:0] base;
  logic restart, write_now, count_en, add_en, in_crop, row_end;
  logic [ACC_W-1:0] acc_rd;
  logic [7:0] gray, avg, wval;

  assign gray    = rgb565_to_gray(pixel_data);
  assign xo      = x - X_LO;
  assign in_crop = (x >= X_LO) && (x < X_HI) && (y >= Y_LO) && (y < Y_HI);
  assign row_end = (x == X_LAST) && (y == row_last);
  assign add_en  = count_en && in_crop;
  assign avg     = 8'(acc_rd >> (2 * BLK_LOG2));
  assign wval    = (INVERT != 0) ? ~avg : avg;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (enable) state_nx = WAIT_VSYNC;
      WAIT_VSYNC: if (!enable) state_nx = IDLE;
                  else if (vsync) state_nx = CAPTURE;
      CAPTURE:    if (count_en && row_end) state_nx = WRITE;
      WRITE:      if (vsync) state_nx = CAPTURE;
                  else if (bx == IDX_LAST) state_nx = (by == IDX_LAST) ? DONE : CAPTURE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // vsync while capturing restarts the frame in place.
  always_comb begin
    busy      = 1'b0;
    restart   = 1'b0;
    write_now = 1'b0;
    count_en  = 1'b0;
    case (state)
      WAIT_VSYNC: begin
        busy    = 1'b1;
        restart = enable && vsync;
      end
      CAPTURE, WRITE: begin
        busy      = 1'b1;
        restart   = vsync;
        count_en  = !vsync && pixel_valid && (y < Y_END);
        write_now = (state == WRITE) && !vsync;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      row_last   <= ROW0_LAST;
      bx         <= '0;
      by         <= '0;
      base       <= '0;
      bram_addr  <= '0;
      bram_din   <= '0;
      bram_we    <= 1'b0;
      bram_en    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bram_we    <= write_now;
      bram_en    <= write_now;
      frame_done <= (state == DONE);
      if (write_now) begin
        bram_addr <= base + ADDR_W'(bx);
        bram_din  <= {8'h00, wval};
      end
      if (restart) begin
        x        <= '0;
        y        <= '0;
        row_last <= ROW0_LAST;
        bx       <= '0;
        by       <= '0;
        base     <= '0;
      end else begin
        if (count_en) begin
          if (x == X_LAST) begin
            x <= '0;
            y <= y + 10'd1;
          end else begin
            x <= x + 10'd1;
          end
        end
        if (write_now) begin
          if (bx == IDX_LAST) begin
            bx       <= '0;
            by       <= by + 1'b1;
            base     <= base + NB_A;
            row_last <= row_last + BLK_V;
          end else begin
            bx <= bx + 1'b1;
          end
        end
      end
    end
  end

  block_row_accumulator #(.NB(NB), .IW(IW), .ACC_W(ACC_W)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all (restart),
    .add_en    (add_en),
    .add_idx   (IW'(xo >> BLK_LOG2)),
    .add_val   (gray),
    .rd_clr    (write_now),
    .rd_idx    (bx),
    .rd_data   (acc_rd)
  );

endmodule

// File: tb/tb_frame_downsample_writer.sv
// tb/tb_frame_downsample_writer.sv - self-checking bench for frame_downsample_writer
module tb_frame_downsample_writer;

  localparam int IMG_W = 64, IMG_H = 56, X0 = 8, Y0 = 4, BLK_LOG2 = 4, NB = 3, INVERT = 1;
  localparam int BLK = 16, NWORDS = NB * NB;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, vsync = 1'b0, pixel_valid = 1'b0;
  logic [15:0] pixel_data = '0;
  logic [9:0]  bram_addr;
  logic [15:0] bram_din;
  logic        bram_we, bram_en, frame_done, busy;

  frame_downsample_writer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0),
    .BLK_LOG2(BLK_LOG2), .NB(NB), .INVERT(INVERT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
    .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_en(bram_en), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, done_seen = 0, done_exp = 0;
  int ea, ed, d0;
  logic [15:0] img [IMG_H][IMG_W];
  logic [15:0] dut_mem [NWORDS];
  int exp_addr_q[$];
  int exp_data_q[$];
  logic last_was_final = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_m(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return (r + 2 * g + b) / 4;
  endfunction

  // Expected writes for the first nrows block rows of the current image.
  task automatic model_rows(input int nrows);
    for (int by = 0; by < nrows; by++)
      for (int bx = 0; bx < NB; bx++) begin
        int sum, avg;
        sum = 0;
        for (int j = 0; j < BLK; j++)
          for (int i = 0; i < BLK; i++)
            sum += gray_m(img[Y0 + by * BLK + j][X0 + bx * BLK + i]);
        avg = sum / (BLK * BLK);
        exp_addr_q.push_back(by * NB + bx);
        exp_data_q.push_back(INVERT != 0 ? 255 - avg : avg);
      end
  endtask

  always @(negedge clk) begin
    if (bram_we || bram_en) begin
      check("en_equals_we", int'(bram_en), int'(bram_we));
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %h, no write required", bram_addr, bram_din);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("write_addr", int'(bram_addr), ea);
        check("write_data", int'(bram_din), ed);
        if (int'(bram_addr) < NWORDS) dut_mem[bram_addr] = bram_din;
      end
    end
    if (frame_done) begin
      done_seen++;
      check("done_follows_last_write", int'(last_was_final), 1);
      check("done_pending_writes", exp_addr_q.size(), 0);
    end
    last_was_final = bram_we && (int'(bram_addr) == NWORDS - 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vsync();
    pixel_valid = 1'b0;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  task automatic stream(input int from, input int to, input bit gaps);
    for (int idx = from; idx < to; idx++) begin
      while (gaps && $urandom_range(3) == 0) begin
        pixel_valid = 1'b0;
        tick();
      end
      pixel_valid = 1'b1;
      pixel_data  = img[idx / IMG_W][idx % IMG_W];
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic fill(input int kind);
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++)
        case (kind)
          0: img[y][x] = 16'hFFFF;
          1: img[y][x] = 16'h0000;
          2: img[y][x] = 16'hF800;
          3: img[y][x] = (x == X0 && y == Y0) ? 16'hFFFF : 16'h0000;
          4: img[y][x] = (x >= X0 && x < X0 + BLK && y >= Y0 && y < Y0 + BLK) ? 16'hFFFF : 16'h0000;
          5: img[y][x] = (x == X0 - 1 || x == X0 + NB * BLK) ? 16'hFFFF : 16'h0000;
          default: img[y][x] = 16'($urandom);
        endcase
  endtask

  task automatic run_frame(input bit gaps);
    model_rows(NB);
    done_exp++;
    send_vsync();
    stream(0, IMG_W * IMG_H, gaps);
    repeat (4) tick();
    check("frame_all_written", exp_addr_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) dut_mem[i] = 16'hDEAD;
    repeat (3) tick();
    @(negedge clk);
    check("reset_we", int'(bram_we), 0);
    check("reset_en", int'(bram_en), 0);
    check("reset_done", int'(frame_done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_addr", int'(bram_addr), 0);
    check("reset_din", int'(bram_din), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    @(negedge clk);
    check("busy_armed", int'(busy), 1);

    fill(0); run_frame(0);
    check("white_word0", int'(dut_mem[0]), 16'h0000);
    check("white_word_last", int'(dut_mem[NWORDS - 1]), 16'h0000);
    check("model_gray_white", gray_m(16'hFFFF), 255);

    fill(1); run_frame(0);
    check("black_word4", int'(dut_mem[4]), 16'h00FF);

    fill(2); run_frame(0);
    check("red_word4", int'(dut_mem[4]), 16'h00C0);
    check("model_gray_red", gray_m(16'hF800), 63);

    fill(3); run_frame(0);
    check("single_pixel_word0", int'(dut_mem[0]), 16'h00FF);

    fill(4); run_frame(0);
    check("block_word0", int'(dut_mem[0]), 16'h0000);
    check("block_word1", int'(dut_mem[1]), 16'h00FF);
    check("block_word3", int'(dut_mem[3]), 16'h00FF);

    fill(5); run_frame(0);
    check("edge_word0", int'(dut_mem[0]), 16'h00FF);
    check("edge_word2", int'(dut_mem[2]), 16'h00FF);

    fill(6); run_frame(1);

    // Abort mid block row 1, then a full frame restarts at address 0.
    fill(0);
    d0 = done_seen;
    model_rows(1);
    send_vsync();
    stream(0, (Y0 + BLK + 5) * IMG_W, 0);
    run_frame(0);
    check("abort_single_done", done_seen, d0 + 1);

    // Reset during the second write of block row 0.
    fill(0);
    exp_addr_q.push_back(0);
    exp_data_q.push_back(0);
    send_vsync();
    stream(0, (Y0 + BLK) * IMG_W, 0);
    stream((Y0 + BLK) * IMG_W, (Y0 + BLK) * IMG_W + 1, 0);
    d0 = done_seen;
    pixel_valid = 1'b1;
    pixel_data = 16'hFFFF;
    rst_n = 1'b0;
    tick();
    pixel_valid = 1'b0;
    @(negedge clk);
    check("rst_write_we", int'(bram_we), 0);
    check("rst_write_busy", int'(busy), 0);
    check("rst_write_done", int'(frame_done), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (60) tick();
    check("rst_no_done", done_seen, d0);
    check("rst_no_pending", exp_addr_q.size(), 0);
    run_frame(0);
    check("rearm_word_last", int'(dut_mem[NWORDS - 1]), 16'h0000);

    check("done_count", done_seen, done_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
